dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the MIPS core's load/store path and an external master (loader/debug DMA). It sits between the core's memory signals (ALU result as address, ReadData2 as write data, MemRead/MemWrite) and the RAM. It issues at most one memory access per cycle, routes read data back, and produces `cpu_stall` to freeze the core's PC and register-file write until the core's access completes.

---
 rtl/dmem_arb_pkg.sv | 12 +
 rtl/dmem_arb_starve_cnt.sv | 27 ++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: requester indices and default widths.
package dmem_arb_pkg;
  localparam int REQ_CPU          = 0;
  localparam int REQ_EXT          = 1;
  localparam int NUM_REQ          = 2;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W     = 8;

  typedef logic [NUM_REQ-1:0] req_vec_t;
endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating wait counter for the external requester; limit_hit lets ext win a contended cycle.
module dmem_arb_starve_cnt #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_limit_hit
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_limit_hit = (r_cnt == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// CPU / external-master arbiter for the single-port data memory.
// Optional starvation override for the external master is built when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT out of range 1..255");
  end

  req_vec_t r_out;
  req_vec_t w_out;
  req_vec_t w_req;
  req_vec_t w_we;
  req_vec_t w_elig;
  req_vec_t w_win;
  logic     w_starve_hit;

  assign w_req[REQ_CPU] = cpu_req;
  assign w_req[REQ_EXT] = ext_req;
  assign w_we[REQ_CPU]  = cpu_we;
  assign w_we[REQ_EXT]  = ext_we;

  // Outstanding reads are ignored while reset is held so nothing returns from a flushed access.
  assign w_out  = r_out & {NUM_REQ{~reset}};
  assign w_elig = w_req & ~w_out;

  always_comb begin
    w_win = '0;
    if (w_elig[REQ_EXT] && (!w_elig[REQ_CPU] || w_starve_hit)) begin
      w_win[REQ_EXT] = 1'b1;
    end else if (w_elig[REQ_CPU]) begin
      w_win[REQ_CPU] = 1'b1;
    end else begin
      w_win = '0;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (w_win[REQ_EXT]) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign mem_en     = |w_win;
  assign mem_we     = |(w_win & w_we);
  assign cpu_gnt    = w_win[REQ_CPU];
  assign ext_gnt    = w_win[REQ_EXT];
  assign cpu_rvalid = w_out[REQ_CPU];
  assign ext_rvalid = w_out[REQ_EXT];
  assign rdata      = mem_rdata;
  assign cpu_stall  = cpu_req & ~((cpu_gnt & cpu_we) | cpu_rvalid);

  // A granted read is outstanding for exactly one cycle; its owner cannot win in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_win & ~w_we;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (STARVE_CNT_W)
  ) u_starve_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_elig[REQ_EXT] & ~w_win[REQ_EXT]),
    .i_clr       (~ext_req | w_win[REQ_EXT]),
    .o_limit_hit (w_starve_hit)
  );
`else
  assign w_starve_hit = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all compared each cycle against a cycle-numbered behavioural model.
module tb_dmem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata, mem_wdata, rdata, mem_rdata;
  logic          ext_req, ext_we, ext_gnt, ext_rvalid;
  logic          mem_en, mem_we;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycle index of each requester's last read grant, and ext waiting time.
  int cyc        = 0;
  int cpu_rd_cyc = -10;
  int ext_rd_cyc = -10;
  int ext_wait   = 0;
  logic e_cpu_gnt, e_ext_gnt, e_cpu_rv, e_ext_rv;
  int first_ext;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic ce, ee, stall_x;
    @(negedge clk);
    e_cpu_rv  = !reset && (cpu_rd_cyc == cyc - 1);
    e_ext_rv  = !reset && (ext_rd_cyc == cyc - 1);
    ce        = cpu_req && !e_cpu_rv;
    ee        = ext_req && !e_ext_rv;
    e_ext_gnt = ee && (!ce || (STARVE_EN && (ext_wait >= LIM)));
    e_cpu_gnt = ce && !e_ext_gnt;
    stall_x   = cpu_req && !((e_cpu_gnt && cpu_we) || e_cpu_rv);
    chk("cpu_gnt", cpu_gnt, e_cpu_gnt);
    chk("ext_gnt", ext_gnt, e_ext_gnt);
    chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
    chk("ext_rvalid", ext_rvalid, e_ext_rv);
    chk("cpu_stall", cpu_stall, stall_x);
    chk("mem_en", mem_en, e_cpu_gnt || e_ext_gnt);
    chk("mem_we", mem_we, (e_cpu_gnt && cpu_we) || (e_ext_gnt && ext_we));
    chk("mem_addr", mem_addr, e_ext_gnt ? ext_addr : cpu_addr);
    chk("mem_wdata", mem_wdata, e_ext_gnt ? ext_wdata : cpu_wdata);
    chk("rdata", rdata, mem_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      cpu_rd_cyc = -10;
      ext_rd_cyc = -10;
      ext_wait   = 0;
    end else begin
      if (e_cpu_gnt && !cpu_we) cpu_rd_cyc = cyc;
      if (e_ext_gnt && !ext_we) ext_rd_cyc = cyc;
      if (!ext_req || e_ext_gnt) ext_wait = 0;
      else if (!e_ext_rv && (ext_wait < LIM)) ext_wait++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_rdata = 32'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
    sample(); advance();
    sample(); advance();
    reset = 1'b0;
    sample(); chk("idle_rv", cpu_rvalid, 1'b0); advance();

    // CPU read alone
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    sample(); chk("t1_gnt", cpu_gnt, 1'b1); chk("t1_stall_n", cpu_stall, 1'b1); advance();
    mem_rdata = 32'hDEADBEEF;
    sample();
    chk("t1_rvalid", cpu_rvalid, 1'b1); chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_stall_n1", cpu_stall, 1'b0); chk("t1_no_ext_rv", ext_rvalid, 1'b0);
    advance();
    cpu_req = 1'b0;
    sample(); advance();

    // CPU write with ext write pending
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h5A5A5A5A;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h44; ext_wdata = 32'h00001234;
    sample();
    chk("t2_cpu_gnt", cpu_gnt, 1'b1); chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h20); chk("t2_stall", cpu_stall, 1'b0);
    advance();
    cpu_req = 1'b0;
    sample(); chk("t2_ext_gnt", ext_gnt, 1'b1); chk("t2_ext_addr", mem_addr, 32'h44); advance();
    ext_req = 1'b0;

    // CPU read then ext read back-to-back
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h50;
    sample(); chk("t3_cpu_first", cpu_gnt, 1'b1); advance();
    mem_rdata = 32'h11111111;
    sample(); chk("t3_cpu_rv", cpu_rvalid, 1'b1); chk("t3_ext_gnt", ext_gnt, 1'b1); advance();
    cpu_req = 1'b0; ext_req = 1'b0; mem_rdata = 32'h22222222;
    sample(); chk("t3_ext_rv", ext_rvalid, 1'b1); chk("t3_cpu_rv_off", cpu_rvalid, 1'b0); advance();

    // Continuous CPU writes against a held ext write
    cpu_req = 1'b1; cpu_we = 1'b1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h60; ext_wdata = 32'hCAFE0000;
    first_ext = 0;
    for (int k = 1; k <= 20; k++) begin
      cpu_addr = k; cpu_wdata = 32'h100 + k;
      sample();
      if (ext_gnt && (first_ext == 0)) first_ext = k;
      advance();
    end
    chk("starve_first", first_ext, STARVE_EN ? (LIM + 1) : 0);
    cpu_req = 1'b0; ext_req = 1'b0;
    sample(); advance();

    // Reset right after a CPU read grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h70;
    sample(); chk("t5_gnt", cpu_gnt, 1'b1); advance();
    reset = 1'b1;
    sample(); chk("t5_rst_rv", cpu_rvalid, 1'b0); chk("t5_rst_gnt", cpu_gnt, 1'b1); advance();
    reset = 1'b0;
    sample(); chk("t5_post_gnt", cpu_gnt, 1'b1); chk("t5_post_rv", cpu_rvalid, 1'b0); advance();
    cpu_req = 1'b0;
    sample(); advance();

    // Randomized traffic; ext holds its request until granted
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      if (!ext_req || e_ext_gnt) begin
        ext_req   = ($urandom_range(0, 2) != 0);
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = $urandom;
        ext_wdata = $urandom;
      end
      mem_rdata = $urandom;
      sample(); advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
